mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the IF/MEM stage logic and the unified memory.
- Replaces direct RAM wiring so fetch and data accesses can coexist once stages overlap.
- Request/acknowledge handshake per port; registered RAM-side outputs; fixed-latency read capture.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM between instruction fetch
// (read-only) and data load/store, with req/ack handshakes and fixed-latency read capture.
module mem_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state;
    logic        grant_if;
    logic        grant_we;
    logic [2:0]  lat_cnt;
    logic [3:0]  starve_cnt;
    logic        fetch_wins;

    // Data has priority unless fetch has lost STARVE_MAX arbitrations in a row.
    assign fetch_wins = if_req && (!d_req || (starve_cnt == 4'(STARVE_MAX)));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_if   <= 1'b0;
            grant_we   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            ram_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end
                    if (if_req || d_req) begin
                        ram_en <= 1'b1;
                        state  <= ACCESS;
                        if (fetch_wins) begin
                            grant_if   <= 1'b1;
                            grant_we   <= 1'b0;
                            ram_we     <= 1'b0;
                            ram_addr   <= if_addr;
                            ram_wdata  <= '0;
                            starve_cnt <= '0;
                        end else begin
                            grant_if  <= 1'b0;
                            grant_we  <= d_we;
                            ram_we    <= d_we;
                            ram_addr  <= d_addr;
                            ram_wdata <= d_wdata;
                            if (if_req && (starve_cnt != 4'(STARVE_MAX))) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    ram_we <= 1'b0;
                    // Only the data port can write, so a write completion always acks data.
                    if (grant_we) begin
                        state <= RESP;
                        d_ack <= 1'b1;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= 3'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        state <= RESP;
                        if (grant_if) begin
                            if_rdata <= ram_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            d_rdata <= ram_rdata;
                            d_ack   <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: main instance at RD_LAT=2 plus
// fetch-only instances at RD_LAT=1 and RD_LAT=4.
module tb_mem_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM model with a two-stage read pipeline; poison value exposes early/late capture.
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:1];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 32'hBAD0_BAD0;
        rd_pipe[1] <= rd_pipe[0];
    end
    assign ram_rdata = rd_pipe[1];

    int en_cnt = 0, if_ack_cnt = 0, d_ack_cnt = 0, both_cnt = 0;
    logic [AW-1:0] en_addr;
    logic          en_we;
    logic [DW-1:0] en_wdata;

    always @(posedge clk) begin
        if (ram_en) begin
            en_cnt   <= en_cnt + 1;
            en_addr  <= ram_addr;
            en_we    <= ram_we;
            en_wdata <= ram_wdata;
        end
        if (if_ack) if_ack_cnt <= if_ack_cnt + 1;
        if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
        if (if_ack && d_ack) both_cnt <= both_cnt + 1;
    end

    // Latency-variant instances: fetch only, RAM returns a pattern derived from the address.
    logic          lat_req   [2];
    logic [AW-1:0] lat_addr  [2];
    logic          lat_ack   [2];
    logic [DW-1:0] lat_rdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int LAT = (g == 0) ? 1 : 4;
        logic          en, we, bsy, dack;
        logic [AW-1:0] raddr;
        logic [DW-1:0] rwdata, drdata, rrdata;
        logic [DW-1:0] pipe [0:3];

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_MAX(4)) u_lat (
            .clk(clk), .reset_n(reset_n),
            .if_req(lat_req[g]), .if_addr(lat_addr[g]), .if_ack(lat_ack[g]),
            .if_rdata(lat_rdata[g]),
            .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
            .d_ack(dack), .d_rdata(drdata),
            .ram_en(en), .ram_we(we), .ram_addr(raddr), .ram_wdata(rwdata),
            .ram_rdata(rrdata), .busy(bsy)
        );

        always @(posedge clk) begin
            pipe[0] <= (en && !we) ? (32'h5A00_0000 | 32'(raddr)) : 32'hBAD0_BAD0;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign rrdata = pipe[LAT-1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit fetch, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        if (fetch) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
        end
    endtask

    // Returns the cycle (1 = cycle after the sampling edge) in which ack appeared, -1 on timeout.
    task automatic wait_ack(input bit fetch, output int k);
        bit seen = 1'b0;
        k = 0;
        while (!seen && k < 30) begin
            tick();
            k++;
            seen = fetch ? if_ack : d_ack;
        end
        if (!seen) k = -1;
        if (fetch) if_req = 1'b0;
        else d_req = 1'b0;
    endtask

    initial begin
        int k, e0, a0, dk, fen, ik, dcnt, round;
        int rounds [2];
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        lat_req[0] = 1'b0; lat_req[1] = 1'b0; lat_addr[0] = '0; lat_addr[1] = '0;
        pl_en = 1'b1; pl_addr = 15'h0010; pl_data = 32'hDEAD_BEEF;
        tick();
        pl_addr = 15'h0030; pl_data = 32'h3030_3030;
        tick();
        pl_addr = 15'h0040; pl_data = 32'hCAFE_F00D;
        tick();
        pl_en = 1'b0;
        checkOutput("reset_ctrl", 32'({busy, ram_en, ram_we, if_ack, d_ack}), 32'h0);
        checkOutput("reset_if_rdata", if_rdata, 32'h0);
        checkOutput("reset_d_rdata", d_rdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // Fetch read of a preloaded word.
        e0 = en_cnt; a0 = d_ack_cnt;
        applyStimulus(1'b1, 1'b0, 15'h0010, '0);
        wait_ack(1'b1, k);
        checkOutput("fetch_ack_cycle", 32'(k), 32'd4);
        checkOutput("fetch_en_count", 32'(en_cnt - e0), 32'd1);
        checkOutput("fetch_ram_addr", 32'(en_addr), 32'h0010);
        checkOutput("fetch_ram_we", 32'(en_we), 32'h0);
        checkOutput("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        checkOutput("fetch_no_d_ack", 32'(d_ack_cnt - a0), 32'd0);
        tick();

        // Data write, then read back.
        e0 = en_cnt;
        applyStimulus(1'b0, 1'b1, 15'h0020, 32'h1234_5678);
        wait_ack(1'b0, k);
        checkOutput("write_ack_cycle", 32'(k), 32'd2);
        checkOutput("write_en_count", 32'(en_cnt - e0), 32'd1);
        checkOutput("write_ram_we", 32'(en_we), 32'h1);
        checkOutput("write_ram_addr", 32'(en_addr), 32'h0020);
        checkOutput("write_ram_wdata", en_wdata, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0020, '0);
        wait_ack(1'b0, k);
        checkOutput("read_ack_cycle", 32'(k), 32'd4);
        checkOutput("read_d_rdata", d_rdata, 32'h1234_5678);
        checkOutput("read_if_rdata_held", if_rdata, 32'hDEAD_BEEF);
        tick();

        // Simultaneous requests: data first, fetch after one IDLE cycle.
        dk = -1; fen = -1; ik = -1;
        applyStimulus(1'b0, 1'b0, 15'h0030, '0);
        applyStimulus(1'b1, 1'b0, 15'h0040, '0);
        for (int c = 1; c <= 30 && ik < 0; c++) begin
            tick();
            if (d_ack) begin
                dk = c;
                d_req = 1'b0;
            end
            if (ram_en && ram_addr == 15'h0040 && fen < 0) fen = c;
            if (if_ack) begin
                ik = c;
                if_req = 1'b0;
            end
        end
        checkOutput("both_d_ack_cycle", 32'(dk), 32'd4);
        checkOutput("both_fetch_en_cycle", 32'(fen), 32'd6);
        checkOutput("both_if_ack_cycle", 32'(ik), 32'd9);
        checkOutput("both_d_rdata", d_rdata, 32'h3030_3030);
        checkOutput("both_if_rdata", if_rdata, 32'hCAFE_F00D);
        tick();

        // Starvation: data re-requests continuously, fetch held high for two grants.
        dcnt = 0; round = 0; rounds[0] = -1; rounds[1] = -1;
        applyStimulus(1'b0, 1'b0, 15'h0030, '0);
        applyStimulus(1'b1, 1'b0, 15'h0040, '0);
        for (int c = 0; c < 200 && round < 2; c++) begin
            tick();
            if (d_ack) dcnt++;
            if (if_ack) begin
                rounds[round] = dcnt;
                dcnt = 0;
                round++;
            end
        end
        if_req = 1'b0;
        d_req = 1'b0;
        checkOutput("starve_round1_data_wins", 32'(rounds[0]), 32'd4);
        checkOutput("starve_round2_data_wins", 32'(rounds[1]), 32'd4);
        tick();
        tick();

        // Reset while a fetch read sits in WAIT.
        a0 = if_ack_cnt + d_ack_cnt;
        applyStimulus(1'b1, 1'b0, 15'h0010, '0);
        tick();
        tick();
        checkOutput("wait_busy_before_reset", 32'(busy), 32'h1);
        reset_n = 1'b0;
        if_req = 1'b0;
        tick();
        checkOutput("midreset_ctrl", 32'({busy, ram_en, if_ack, d_ack}), 32'h0);
        checkOutput("midreset_if_rdata", if_rdata, 32'h0);
        reset_n = 1'b1;
        repeat (6) tick();
        checkOutput("midreset_no_ack", 32'(if_ack_cnt + d_ack_cnt - a0), 32'd0);
        applyStimulus(1'b1, 1'b0, 15'h0040, '0);
        wait_ack(1'b1, k);
        checkOutput("post_reset_ack_cycle", 32'(k), 32'd4);
        checkOutput("post_reset_rdata", if_rdata, 32'hCAFE_F00D);
        tick();

        // Read-latency variants.
        for (int g = 0; g < 2; g++) begin
            lat_addr[g] = 15'(15'h0123 + g);
            lat_req[g] = 1'b1;
            k = -1;
            for (int c = 1; c <= 30 && k < 0; c++) begin
                tick();
                if (lat_ack[g]) k = c;
            end
            lat_req[g] = 1'b0;
            checkOutput(g == 0 ? "lat1_ack_cycle" : "lat4_ack_cycle", 32'(k), g == 0 ? 32'd3 : 32'd6);
            checkOutput(g == 0 ? "lat1_rdata" : "lat4_rdata", lat_rdata[g],
                        32'h5A00_0000 | 32'(lat_addr[g]));
            tick();
        end

        checkOutput("acks_never_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
